// File: rtl/db4_interp_if.sv
// Sample-stream bundle between the DB4 analysis decimator and the synthesis
// interpolator: decimated input strobe in, full-rate interpolated output back.
interface db4_interp_if #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 9
);
    logic signed [IN_W-1:0]  x_in;
    logic                    x_valid;
    logic signed [OUT_W-1:0] y_out;
    logic                    y_valid;
    logic                    y_phase;
    logic                    overrun;

    modport master (
        output x_in, x_valid,
        input  y_out, y_valid, y_phase, overrun
    );

    modport slave (
        input  x_in, x_valid,
        output y_out, y_valid, y_phase, overrun
    );
endinterface

// File: rtl/db4_interp.sv
// Daubechies-4 synthesis lowpass, polyphase interpolate-by-2: each accepted
// half-rate sample yields an even then an odd output on consecutive clocks.
module db4_interp #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 9,
    parameter int ACC_W = 18
) (
    input  logic            clk,
    input  logic            reset,
    db4_interp_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

    state_t                  state_q, state_d;
    logic signed [IN_W-1:0]  x0_q, x0_d;
    logic signed [IN_W-1:0]  x1_q, x1_d;
    logic signed [OUT_W-1:0] y_out_q, y_out_d;
    logic                    y_valid_q, y_valid_d;
    logic                    y_phase_q, y_phase_d;
    logic                    overrun_q, overrun_d;
    logic                    accept;

    logic signed [ACC_W-1:0] s0, s1;
    logic signed [ACC_W-1:0] even_acc, odd_acc;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] x);
        return ACC_W'(x);
    endfunction

    // Floor division by 256; the filter gain guarantees the result fits OUT_W.
    function automatic logic signed [OUT_W-1:0] scale_down(input logic signed [ACC_W-1:0] acc);
        return OUT_W'(acc >>> 8);
    endfunction

    assign s0 = sext(x0_q);
    assign s1 = sext(x1_q);

    // Even phase: -33*x0 + 214*x1 ; odd phase: 57*x0 + 124*x1, all shift-add.
    assign even_acc = -(s0 <<< 5) - s0
                    + (s1 <<< 7) + (s1 <<< 6) + (s1 <<< 4) + (s1 <<< 2) + (s1 <<< 1);
    assign odd_acc  = (s0 <<< 6) - (s0 <<< 3) + s0
                    + (s1 <<< 7) - (s1 <<< 2);

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y_out_d   = y_out_q;
        y_valid_d = y_valid_q;
        y_phase_d = y_phase_q;
        overrun_d = overrun_q;
        accept    = bus.x_valid && (state_q == IDLE || state_q == ODD);

        if (accept) begin
            x1_d = x0_q;
            x0_d = bus.x_in;
        end

        case (state_q)
            IDLE: begin
                y_valid_d = 1'b0;
                if (accept) state_d = EVEN;
            end
            EVEN: begin
                y_out_d   = scale_down(even_acc);
                y_valid_d = 1'b1;
                y_phase_d = 1'b0;
                state_d   = ODD;
                // A strobe here arrives faster than the odd phase can drain.
                if (bus.x_valid) overrun_d = 1'b1;
            end
            ODD: begin
                y_out_d   = scale_down(odd_acc);
                y_valid_d = 1'b1;
                y_phase_d = 1'b1;
                state_d   = accept ? EVEN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            y_phase_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
            y_phase_q <= y_phase_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_phase = y_phase_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_db4_interp.sv
// Bench for db4_interp: hand-computed vector table for the directed cases,
// then random strobe/data traffic against a sample-level reference model.
module tb_db4_interp;

    logic clk = 1'b0;
    logic reset;

    db4_interp_if #(.IN_W(9), .OUT_W(9)) bus ();

    db4_interp #(.IN_W(9), .OUT_W(9), .ACC_W(18)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit v;
        int x;
        int ey;
        bit ev;
        bit ep;
        bit eo;
    } vec_t;

    typedef struct {
        int due;
        int val;
        bit ph;
    } pend_t;

    vec_t  vecs[$];
    pend_t pend[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: taps, last accepted edge, registered outputs.
    int m_t, m_last, m_x0, m_x1, m_y;
    bit m_v, m_p, m_ov;

    task automatic add(input bit rst, input bit v, input int x,
                       input int ey, input bit ev, input bit ep, input bit eo);
        vec_t r;
        r.rst = rst; r.v = v; r.x = x; r.ey = ey; r.ev = ev; r.ep = ep; r.eo = eo;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input int x);
        reset       = rst;
        bus.x_valid = v;
        bus.x_in    = 9'(x);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx,
                             input int ey, input bit ev, input bit ep, input bit eo);
        chk({tag, ".y_out"},   idx, int'(bus.y_out), ey);
        chk({tag, ".y_valid"}, idx, int'(bus.y_valid), int'(ev));
        chk({tag, ".y_phase"}, idx, int'(bus.y_phase), int'(ep));
        chk({tag, ".overrun"}, idx, int'(bus.overrun), int'(eo));
    endtask

    // Filter defined directly from the synthesis taps with floor division.
    function automatic int floor256(input int p);
        return p >>> 8;
    endfunction

    task automatic model_edge(input bit rst, input bit v, input int x);
        pend_t e;
        if (rst) begin
            pend.delete();
            m_last = -100;
            m_x0 = 0; m_x1 = 0; m_y = 0;
            m_v = 0; m_p = 0; m_ov = 0;
        end else begin
            m_v = 0;
            if (pend.size() > 0 && pend[0].due == m_t) begin
                m_y = pend[0].val;
                m_p = pend[0].ph;
                m_v = 1;
                void'(pend.pop_front());
            end
            if (v) begin
                if (m_t - m_last < 2) begin
                    m_ov = 1;
                end else begin
                    m_x1 = m_x0;
                    m_x0 = x;
                    m_last = m_t;
                    e.due = m_t + 1; e.ph = 0;
                    e.val = floor256(-33 * m_x0 + 214 * m_x1);
                    pend.push_back(e);
                    e.due = m_t + 2; e.ph = 1;
                    e.val = floor256(57 * m_x0 + 124 * m_x1);
                    pend.push_back(e);
                end
            end
        end
        m_t++;
    endtask

    initial begin
        reset       = 1'b1;
        bus.x_valid = 1'b0;
        bus.x_in    = '0;

        // Impulse 100 then zeros
        add(1, 0, 0,      0, 0, 0, 0);
        add(0, 1, 100,    0, 0, 0, 0);
        add(0, 0, 0,    -13, 1, 0, 0);
        add(0, 1, 0,     22, 1, 1, 0);
        add(0, 0, 0,     83, 1, 0, 0);
        add(0, 0, 0,     48, 1, 1, 0);
        add(0, 1, 0,     48, 0, 1, 0);
        add(0, 0, 0,      0, 1, 0, 0);
        add(0, 0, 0,      0, 1, 1, 0);
        add(0, 0, 0,      0, 0, 1, 0);
        // Full-scale extremes, back-to-back streaming
        add(1, 0, 0,      0, 0, 0, 0);
        add(0, 1, -256,   0, 0, 0, 0);
        add(0, 0, 0,     33, 1, 0, 0);
        add(0, 1, 255,  -57, 1, 1, 0);
        add(0, 0, 0,   -247, 1, 0, 0);
        add(0, 1, -256, -68, 1, 1, 0);
        add(0, 0, 0,    246, 1, 0, 0);
        add(0, 1, -256,  66, 1, 1, 0);
        add(0, 0, 0,   -181, 1, 0, 0);
        add(0, 0, 0,   -181, 1, 1, 0);
        add(0, 0, 0,   -181, 0, 1, 0);
        // Overrun: second strobe of a consecutive pair is dropped, flag sticks
        add(1, 0, 0,      0, 0, 0, 0);
        add(0, 1, 100,    0, 0, 0, 0);
        add(0, 1, 50,   -13, 1, 0, 1);
        add(0, 0, 0,     22, 1, 1, 1);
        add(0, 0, 0,     22, 0, 1, 1);
        add(0, 1, 0,     22, 0, 1, 1);
        add(0, 0, 0,     83, 1, 0, 1);
        add(0, 0, 0,     48, 1, 1, 1);
        // DC 200 streaming, then reset mid-burst overriding strobes
        add(1, 0, 0,      0, 0, 0, 0);
        add(0, 1, 200,    0, 0, 0, 0);
        add(0, 0, 0,    -26, 1, 0, 0);
        add(0, 1, 200,   44, 1, 1, 0);
        add(0, 0, 0,    141, 1, 0, 0);
        add(0, 1, 200,  141, 1, 1, 0);
        add(0, 0, 0,    141, 1, 0, 0);
        add(0, 1, 200,  141, 1, 1, 0);
        add(1, 0, 0,      0, 0, 0, 0);
        add(1, 1, 77,     0, 0, 0, 0);
        add(1, 1, 77,     0, 0, 0, 0);
        add(0, 1, 100,    0, 0, 0, 0);
        add(0, 0, 0,    -13, 1, 0, 0);
        add(0, 0, 0,     22, 1, 1, 0);
        // Strobes 5 clocks apart: idle gaps hold y_out, taps carry over
        add(0, 0, 0,     22, 0, 1, 0);
        add(0, 1, -100,  22, 0, 1, 0);
        add(0, 0, 0,     96, 1, 0, 0);
        add(0, 0, 0,     26, 1, 1, 0);
        add(0, 0, 0,     26, 0, 1, 0);
        add(0, 0, 0,     26, 0, 1, 0);
        add(0, 1, 50,    26, 0, 1, 0);
        add(0, 0, 0,    -91, 1, 0, 0);
        add(0, 0, 0,    -38, 1, 1, 0);
        add(0, 0, 0,    -38, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].x);
            check_all("vec", i, vecs[i].ey, vecs[i].ev, vecs[i].ep, vecs[i].eo);
        end

        // Random traffic including rate violations and occasional resets
        m_t = 0;
        model_edge(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check_all("rnd", 0, m_y, m_v, m_p, m_ov);
        for (int k = 1; k < 3000; k++) begin
            bit rr, vv;
            int xx;
            rr = ($urandom_range(0, 199) == 0);
            vv = ($urandom_range(0, 9) < 4);
            xx = int'($urandom_range(0, 511)) - 256;
            model_edge(rr, vv, xx);
            step(rr, vv, xx);
            check_all("rnd", k, m_y, m_v, m_p, m_ov);
        end

        bus.x_valid = 1'b0;
        reset       = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
